// File: rtl/ram_b_arbiter_if.sv
// ram_b_arbiter_if - request/response bundle between one RAM_B master and
// the arbiter.
//   req       access request, held with its fields until gnt
//   we        1 = store, 0 = load
//   addr      byte address
//   wdata     store data, right-aligned
//   u_b_h_w   size code: bit0 = half, bit1 = word, neither = byte, bit2 = unsigned
//   gnt       request accepted this cycle
//   done      one-cycle pulse, access finished
//   err       valid with done, access rejected
//   rdata     load result, valid with done, held until the next done
interface ram_b_arbiter_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [2:0]  u_b_h_w;
   logic        gnt;
   logic        done;
   logic        err;
   logic [31:0] rdata;

   modport master (
      output req, we, addr, wdata, u_b_h_w,
      input  gnt, done, err, rdata
   );

   modport slave (
      input  req, we, addr, wdata, u_b_h_w,
      output gnt, done, err, rdata
   );
endinterface

// File: rtl/ram_b_arbiter.sv
// ram_b_arbiter - two-master round-robin arbiter/sequencer in front of the
// 128-byte RAM_B. One access at a time: grant in IDLE, one ACCESS cycle that
// drives the RAM from registered request fields, done/err/rdata returned to
// the owner on the closing edge.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   m0, m1            master buses (m0 = core MEM stage, m1 = debug loader)
//   ram_addr/din/we   RAM port A address, write data, write enable
//   ram_u_b_h_w       RAM size/sign code
//   ram_dout          RAM combinational read data (already extended)
//
// Optional: define RAM_B_ARB_MISALIGN_CHK_EN to reject misaligned half/word
// accesses with err instead of passing them to the RAM.
//
// state  | meaning
// IDLE   | waiting for a request; gnt is combinational here
// ACCESS | RAM driven from latched fields; result captured at the next edge
module ram_b_arbiter #(
   parameter int   RAM_AW     = 7,
   parameter logic RESET_LAST = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   ram_b_arbiter_if.slave        m0,
   ram_b_arbiter_if.slave        m1,
   output logic [31:0]           ram_addr,
   output logic [31:0]           ram_din,
   output logic                  ram_we,
   output logic [2:0]            ram_u_b_h_w,
   input  logic [31:0]           ram_dout
);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t      state;
   logic        last;
   logic        owner;
   logic        lat_we;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic [2:0]  lat_size;

   logic        pick1;
   logic        gnt0;
   logic        gnt1;
   logic        err_cond;
   logic [31:0] rd_val;

   // On a tie the master that did not win last time goes first.
   assign pick1 = m1.req & (~m0.req | ~last);
   assign gnt0  = (state == IDLE) & ~rst & m0.req & ~pick1;
   assign gnt1  = (state == IDLE) & ~rst & pick1;

   assign m0.gnt = gnt0;
   assign m1.gnt = gnt1;

`ifdef RAM_B_ARB_MISALIGN_CHK_EN
   logic misalign;
   assign misalign = (lat_size[0] & lat_addr[0]) | (lat_size[1] & (|lat_addr[1:0]));
   assign err_cond = (|lat_addr[31:RAM_AW]) | misalign;
`else
   assign err_cond = |lat_addr[31:RAM_AW];
`endif

   // Not gated by rst: a write already in its ACCESS cycle still commits.
   assign ram_we      = (state == ACCESS) & lat_we & ~err_cond;
   assign ram_addr    = lat_addr;
   assign ram_din     = lat_wdata;
   assign ram_u_b_h_w = lat_size;

   assign rd_val = (lat_we | err_cond) ? 32'h0 : ram_dout;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         last      <= RESET_LAST;
         owner     <= 1'b0;
         lat_we    <= 1'b0;
         lat_addr  <= 32'h0;
         lat_wdata <= 32'h0;
         lat_size  <= 3'h0;
         m0.done   <= 1'b0;
         m0.err    <= 1'b0;
         m0.rdata  <= 32'h0;
         m1.done   <= 1'b0;
         m1.err    <= 1'b0;
         m1.rdata  <= 32'h0;
      end else begin
         m0.done <= 1'b0;
         m0.err  <= 1'b0;
         m1.done <= 1'b0;
         m1.err  <= 1'b0;
         case (state)
            IDLE: begin
               if (gnt0 | gnt1) begin
                  owner     <= gnt1;
                  last      <= gnt1;
                  lat_we    <= gnt1 ? m1.we      : m0.we;
                  lat_addr  <= gnt1 ? m1.addr    : m0.addr;
                  lat_wdata <= gnt1 ? m1.wdata   : m0.wdata;
                  lat_size  <= gnt1 ? m1.u_b_h_w : m0.u_b_h_w;
                  state     <= ACCESS;
               end
            end
            ACCESS: begin
               if (owner) begin
                  m1.done  <= 1'b1;
                  m1.err   <= err_cond;
                  m1.rdata <= rd_val;
               end else begin
                  m0.done  <= 1'b1;
                  m0.err   <= err_cond;
                  m0.rdata <= rd_val;
               end
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_b_arbiter.sv
module tb_ram_b_arbiter;

`ifdef RAM_B_ARB_MISALIGN_CHK_EN
   localparam bit MIS = 1'b1;
`else
   localparam bit MIS = 1'b0;
`endif

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  sz;
   } req_t;

   typedef struct {
      bit          m;
      req_t        q;
      bit          err;
      logic [31:0] rd;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ram_addr;
   logic [31:0] ram_din;
   logic        ram_we;
   logic [2:0]  ram_u_b_h_w;
   logic [31:0] ram_dout;

   ram_b_arbiter_if m0_bus();
   ram_b_arbiter_if m1_bus();

   ram_b_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .m0          (m0_bus),
      .m1          (m1_bus),
      .ram_addr    (ram_addr),
      .ram_din     (ram_din),
      .ram_we      (ram_we),
      .ram_u_b_h_w (ram_u_b_h_w),
      .ram_dout    (ram_dout)
   );

   always #5 clk = ~clk;

   // RAM_B environment model: negedge write, combinational extended read.
   logic [7:0] ram_mem [128] = '{default: 8'h00};
   logic [6:0] ra;
   logic [7:0] b0, b1, b2, b3;
   assign ra = ram_addr[6:0];

   always_comb begin
      b0 = ram_mem[ra];
      b1 = ram_mem[ra + 7'd1];
      b2 = ram_mem[ra + 7'd2];
      b3 = ram_mem[ra + 7'd3];
      ram_dout = 32'h0;
      if (ram_u_b_h_w[1])
         ram_dout = {b3, b2, b1, b0};
      else if (ram_u_b_h_w[0])
         ram_dout = ram_u_b_h_w[2] ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
      else
         ram_dout = ram_u_b_h_w[2] ? {24'h0, b0} : {{24{b0[7]}}, b0};
   end

   always @(negedge clk) begin
      if (ram_we) begin
         ram_mem[ra] <= ram_din[7:0];
         if (ram_u_b_h_w[0] | ram_u_b_h_w[1]) ram_mem[ra + 7'd1] <= ram_din[15:8];
         if (ram_u_b_h_w[1]) begin
            ram_mem[ra + 7'd2] <= ram_din[23:16];
            ram_mem[ra + 7'd3] <= ram_din[31:24];
         end
      end
   end

   // Reference model: byte memory plus last-winner pointer.
   logic [7:0] ref_mem [128] = '{default: 8'h00};
   bit         rr_last;

   int n_cmp = 0;
   int n_mis = 0;

   bit          pend_v = 1'b0;
   bit          pend_m;
   bit          pend_err;
   logic [31:0] pend_rd;

   function automatic int nbytes(input logic [2:0] sz);
      return sz[1] ? 4 : (sz[0] ? 2 : 1);
   endfunction

   function automatic bit ref_err(input logic [31:0] a, input logic [2:0] sz);
      bit oor = (a >= 32'd128);
      bit mis = (int'(a % 4) % nbytes(sz)) != 0;
      return oor || (MIS && mis);
   endfunction

   function automatic logic [31:0] ref_read(input logic [31:0] a, input logic [2:0] sz);
      logic [31:0] v = 32'h0;
      logic [6:0]  ix;
      int          n = nbytes(sz);
      for (int i = 0; i < n; i++) begin
         ix = 7'(a + 32'(i));
         v  = v | (32'(ref_mem[ix]) << (8 * i));
      end
      if (!sz[2] && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
      return v;
   endfunction

   task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
      logic [6:0] ix;
      for (int i = 0; i < nbytes(sz); i++) begin
         ix = 7'(a + 32'(i));
         ref_mem[ix] = d[8 * i +: 8];
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input bit r0, input bit r1, input req_t q0, input req_t q1);
      m0_bus.req = r0; m0_bus.we = q0.we; m0_bus.addr = q0.addr;
      m0_bus.wdata = q0.wdata; m0_bus.u_b_h_w = q0.sz;
      m1_bus.req = r1; m1_bus.we = q1.we; m1_bus.addr = q1.addr;
      m1_bus.wdata = q1.wdata; m1_bus.u_b_h_w = q1.sz;
   endtask

   task automatic check_pending();
      if (pend_v) begin
         chk("done_owner", pend_m ? m1_bus.done : m0_bus.done, 1);
         chk("done_other", pend_m ? m0_bus.done : m1_bus.done, 0);
         chk("err",        pend_m ? m1_bus.err  : m0_bus.err,  pend_err);
         chk("rdata",      pend_m ? m1_bus.rdata : m0_bus.rdata, pend_rd);
         pend_v = 1'b0;
      end
   endtask

   // Entered and left 1 time unit after a posedge. The previous access's
   // done is checked in the same cycle as this grant.
   task automatic round(input bit r0, input bit r1, input req_t q0, input req_t q1,
                        input bit exp_m, input bit exp_err, input logic [31:0] exp_rd);
      req_t qw;
      qw = exp_m ? q1 : q0;
      drive(r0, r1, q0, q1);
      #2;
      check_pending();
      chk("gnt0", m0_bus.gnt, !exp_m);
      chk("gnt1", m1_bus.gnt, exp_m);
      chk("we_idle", ram_we, 0);
      @(posedge clk); #1;
      m0_bus.req = 1'b0;
      m1_bus.req = 1'b0;
      #2;
      chk("ram_we", ram_we, qw.we && !exp_err);
      chk("ram_addr", ram_addr, qw.addr);
      chk("ram_din", ram_din, qw.wdata);
      chk("ram_size", ram_u_b_h_w, qw.sz);
      chk("gnt_busy", m0_bus.gnt | m1_bus.gnt, 0);
      rr_last = exp_m;
      @(posedge clk); #1;
      pend_v   = 1'b1;
      pend_m   = exp_m;
      pend_err = exp_err;
      pend_rd  = exp_rd;
   endtask

   task automatic flush();
      #2;
      check_pending();
      @(posedge clk); #3;
      chk("done0_clear", m0_bus.done, 0);
      chk("done1_clear", m1_bus.done, 0);
      @(posedge clk); #1;
   endtask

   vec_t tbl[14];
   req_t idle_q = '{we: 1'b0, addr: 32'h0, wdata: 32'h0, sz: 3'b010};
   req_t rd0_q  = '{we: 1'b0, addr: 32'h0, wdata: 32'h0, sz: 3'b010};

   initial begin
      logic [2:0] codes [5];
      req_t       q0, q1;
      bit         r0, r1, win, e;
      logic [31:0] rd;
      int         pick;
      codes = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};

      tbl[0]  = '{0, '{1, 32'h10, 32'hDEADBEEF, 3'b010}, 0, 32'h0};
      tbl[1]  = '{1, '{0, 32'h10, 32'h0, 3'b010}, 0, 32'hDEADBEEF};
      tbl[2]  = '{0, '{1, 32'h10, 32'h00000080, 3'b000}, 0, 32'h0};
      tbl[3]  = '{0, '{0, 32'h10, 32'h0, 3'b000}, 0, 32'hFFFFFF80};
      tbl[4]  = '{1, '{0, 32'h10, 32'h0, 3'b100}, 0, 32'h00000080};
      tbl[5]  = '{1, '{1, 32'h14, 32'h0000BEEF, 3'b001}, 0, 32'h0};
      tbl[6]  = '{0, '{0, 32'h14, 32'h0, 3'b101}, 0, 32'h0000BEEF};
      tbl[7]  = '{0, '{0, 32'h14, 32'h0, 3'b001}, 0, 32'hFFFFBEEF};
      tbl[8]  = '{1, '{1, 32'h80, 32'h12345678, 3'b010}, 1, 32'h0};
      tbl[9]  = '{1, '{0, 32'h00, 32'h0, 3'b010}, 0, 32'h0};
      tbl[10] = '{0, '{0, 32'h10, 32'h0, 3'b010}, 0, 32'hDEADBE80};
      tbl[11] = '{0, '{0, 32'hFFFF0010, 32'h0, 3'b010}, 1, 32'h0};
      tbl[12] = '{0, '{1, 32'h11, 32'hA5A5A5A5, 3'b010}, MIS, 32'h0};
      tbl[13] = '{0, '{0, 32'h10, 32'h0, 3'b010}, 0, MIS ? 32'hDEADBE80 : 32'hA5A5A580};

      // Reset, with both masters requesting: reset must block grants.
      rst = 1'b1;
      drive(1, 1, rd0_q, rd0_q);
      repeat (2) @(posedge clk);
      #3;
      chk("rst_gnt0", m0_bus.gnt, 0);
      chk("rst_gnt1", m1_bus.gnt, 0);
      chk("rst_done", {m0_bus.done, m1_bus.done, m0_bus.err, m1_bus.err}, 0);
      chk("rst_rdata0", m0_bus.rdata, 0);
      chk("rst_rdata1", m1_bus.rdata, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ram_din", ram_din, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ram_size", ram_u_b_h_w, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Continuous contention: m0, m1, m0, m1 on every other cycle, done
      // of the previous access alongside each new grant.
      for (int c = 0; c <= 8; c++) begin
         if (c == 8) begin
            m0_bus.req = 1'b0;
            m1_bus.req = 1'b0;
         end
         #2;
         chk("rr_gnt0", m0_bus.gnt, (c < 8) && (c % 2 == 0) && ((c / 2) % 2 == 0));
         chk("rr_gnt1", m1_bus.gnt, (c < 8) && (c % 2 == 0) && ((c / 2) % 2 == 1));
         chk("rr_done0", m0_bus.done, (c >= 2) && (c % 2 == 0) && (((c / 2) - 1) % 2 == 0));
         chk("rr_done1", m1_bus.done, (c >= 2) && (c % 2 == 0) && (((c / 2) - 1) % 2 == 1));
         @(posedge clk); #1;
      end
      rr_last = 1'b1;

      // Directed single-master transactions.
      for (int i = 0; i < 14; i++) begin
         round(!tbl[i].m, tbl[i].m,
               tbl[i].m ? idle_q : tbl[i].q, tbl[i].m ? tbl[i].q : idle_q,
               tbl[i].m, tbl[i].err, tbl[i].rd);
      end
      flush();

      // Random traffic against the reference model.
      for (int i = 0; i < 128; i++) ref_mem[i] = ram_mem[i];
      for (int n = 0; n < 80; n++) begin
         q0.we = 1'($urandom); q0.wdata = $urandom; q0.sz = codes[$urandom_range(0, 4)];
         q0.addr = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h80) : 32'($urandom_range(0, 127));
         q1.we = 1'($urandom); q1.wdata = $urandom; q1.sz = codes[$urandom_range(0, 4)];
         q1.addr = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h80) : 32'($urandom_range(0, 127));
         pick = $urandom_range(1, 3);
         r0 = pick[0];
         r1 = pick[1];
         win = (r0 && r1) ? !rr_last : r1;
         e = win ? ref_err(q1.addr, q1.sz) : ref_err(q0.addr, q0.sz);
         if (win ? q1.we : q0.we) begin
            rd = 32'h0;
            if (!e) begin
               if (win) ref_write(q1.addr, q1.wdata, q1.sz);
               else     ref_write(q0.addr, q0.wdata, q0.sz);
            end
         end else begin
            rd = e ? 32'h0 : (win ? ref_read(q1.addr, q1.sz) : ref_read(q0.addr, q0.sz));
         end
         round(r0, r1, q0, q1, win, e, rd);
      end
      flush();

      // Reset during the ACCESS cycle of an m0 byte store.
      drive(1, 0, '{1, 32'h20, 32'h00000055, 3'b000}, idle_q);
      #2;
      chk("rsta_gnt0", m0_bus.gnt, 1);
      @(posedge clk); #1;
      m0_bus.req = 1'b0;
      rst = 1'b1;
      #2;
      chk("rsta_ram_we", ram_we, 1);
      @(posedge clk); #1;
      rst = 1'b0;
      drive(1, 1, rd0_q, rd0_q);
      #2;
      chk("rsta_no_done", m0_bus.done, 0);
      chk("rsta_rdata0", m0_bus.rdata, 0);
      chk("rsta_tie_m0", m0_bus.gnt, 1);
      chk("rsta_tie_m1", m1_bus.gnt, 0);
      chk("rsta_byte20", ram_mem[7'h20], 32'h55);
      @(posedge clk); #1;
      m0_bus.req = 1'b0;
      m1_bus.req = 1'b0;
      @(posedge clk); #3;
      chk("rsta_done_after", m0_bus.done, 1);
      chk("rsta_err_after", m0_bus.err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
